// File: rtl/wbu_commit.sv
// Commit/write-back stage: forms RF/CSR write records from an EXU result and tracks the architectural PC.
// Latency: 1 cycle from accept to o_wb_valid when the 2-entry buffer is empty.
// Backpressure: o_ready is registered and drops when both entries are occupied or after an EBREAK halt.
module wbu_commit #(
  parameter int CPU_WIDTH = 64,
  parameter int REG_AW    = 5,
  parameter logic [CPU_WIDTH-1:0] RESET_PC = {{(CPU_WIDTH-32){1'b0}}, 32'h8000_0000}
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic [CPU_WIDTH-1:0] i_imm,
  input  logic [CPU_WIDTH-1:0] i_rs1,
  input  logic [CPU_WIDTH-1:0] i_exu_res,
  input  logic [CPU_WIDTH-1:0] i_csr,
  input  logic [REG_AW-1:0]    i_rd,
  input  logic                 i_rd_wen,
  input  logic [2:0]           i_kind,
  output logic                 o_wb_valid,
  input  logic                 i_wb_ready,
  output logic                 o_rf_wen,
  output logic [REG_AW-1:0]    o_rf_waddr,
  output logic [CPU_WIDTH-1:0] o_rf_wdata,
  output logic                 o_csr_wen,
  output logic [CPU_WIDTH-1:0] o_csr_wdata,
  output logic [CPU_WIDTH-1:0] o_commit_pc,
  output logic [CPU_WIDTH-1:0] o_next_pc,
  output logic                 o_redirect,
  output logic                 o_illegal,
  output logic                 o_halt,
  output logic [CPU_WIDTH-1:0] o_arch_pc,
  output logic [63:0]          o_commit_cnt
);

  localparam logic [2:0] K_ALU    = 3'd0;
  localparam logic [2:0] K_BRANCH = 3'd1;
  localparam logic [2:0] K_JAL    = 3'd2;
  localparam logic [2:0] K_JALR   = 3'd3;
  localparam logic [2:0] K_CSR    = 3'd4;
  localparam logic [2:0] K_EBREAK = 3'd5;

  typedef struct packed {
    logic                 rf_wen;
    logic [REG_AW-1:0]    rf_waddr;
    logic [CPU_WIDTH-1:0] rf_wdata;
    logic                 csr_wen;
    logic [CPU_WIDTH-1:0] csr_wdata;
    logic [CPU_WIDTH-1:0] commit_pc;
    logic [CPU_WIDTH-1:0] next_pc;
    logic                 redirect;
    logic                 illegal;
  } rec_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t               state_q, state_d;
  rec_t                 out_q, out_d;
  rec_t                 skid_q, skid_d;
  rec_t                 rec;
  logic                 ready_q, ready_d;
  logic                 halt_q, halt_d;
  logic [CPU_WIDTH-1:0] arch_pc_q, arch_pc_d;
  logic [63:0]          cnt_q, cnt_d;
  logic                 accept, drain, is_writer;
  logic [CPU_WIDTH-1:0] pc_plus4, pc_plus_imm, jalr_tgt;

  assign accept      = i_valid & ready_q;
  assign drain       = (state_q != S_EMPTY) & i_wb_ready;
  assign pc_plus4    = i_pc + CPU_WIDTH'(4);
  assign pc_plus_imm = i_pc + i_imm;
  // JALR target always has bit 0 cleared.
  assign jalr_tgt    = (i_rs1 + i_imm) & ~{{(CPU_WIDTH-1){1'b0}}, 1'b1};

  // Build the commit record from the current upstream bundle.
  always_comb begin
    rec           = '0;
    is_writer     = 1'b0;
    rec.commit_pc = i_pc;
    rec.next_pc   = pc_plus4;
    rec.rf_waddr  = i_rd;
    case (i_kind)
      K_ALU: begin
        is_writer    = 1'b1;
        rec.rf_wdata = i_exu_res;
      end
      K_BRANCH: begin
        if (i_exu_res[0]) begin
          rec.next_pc  = pc_plus_imm;
          rec.redirect = 1'b1;
        end
      end
      K_JAL: begin
        is_writer    = 1'b1;
        rec.rf_wdata = i_exu_res;
        rec.next_pc  = pc_plus_imm;
        rec.redirect = 1'b1;
      end
      K_JALR: begin
        is_writer    = 1'b1;
        rec.rf_wdata = i_exu_res;
        rec.next_pc  = jalr_tgt;
        rec.redirect = 1'b1;
      end
      K_CSR: begin
        is_writer     = 1'b1;
        rec.rf_wdata  = i_csr;
        rec.csr_wen   = 1'b1;
        rec.csr_wdata = i_exu_res;
      end
      K_EBREAK: begin
        rec.next_pc = pc_plus4;
      end
      default: begin
        rec.illegal = 1'b1;
      end
    endcase
    // x0 is hardwired to zero, so it is never a write target.
    rec.rf_wen = is_writer & i_rd_wen & (i_rd != '0);
  end

  // Skid-buffer next state, halt, architectural PC and commit counter.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    skid_d    = skid_q;
    halt_d    = halt_q | (accept & (i_kind == K_EBREAK));
    arch_pc_d = accept ? rec.next_pc : arch_pc_q;
    cnt_d     = drain ? cnt_q + 64'd1 : cnt_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          out_d   = rec;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        case ({accept, drain})
          2'b11:   out_d = rec;
          2'b10: begin
            skid_d  = rec;
            state_d = S_FULL;
          end
          2'b01:   state_d = S_EMPTY;
          default: state_d = S_ONE;
        endcase
      end
      S_FULL: begin
        // o_ready is low here, so only a drain can move the buffer.
        if (drain) begin
          out_d   = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    ready_d = (state_d != S_FULL) & ~halt_d;
  end

  // State registers; reset discards any buffered records.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      ready_q   <= 1'b0;
      halt_q    <= 1'b0;
      arch_pc_q <= RESET_PC;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      ready_q   <= ready_d;
      halt_q    <= halt_d;
      arch_pc_q <= arch_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_wb_valid   = (state_q != S_EMPTY);
  assign o_rf_wen     = out_q.rf_wen;
  assign o_rf_waddr   = out_q.rf_waddr;
  assign o_rf_wdata   = out_q.rf_wdata;
  assign o_csr_wen    = out_q.csr_wen;
  assign o_csr_wdata  = out_q.csr_wdata;
  assign o_commit_pc  = out_q.commit_pc;
  assign o_next_pc    = out_q.next_pc;
  assign o_redirect   = out_q.redirect;
  assign o_illegal    = out_q.illegal;
  assign o_halt       = halt_q;
  assign o_arch_pc    = arch_pc_q;
  assign o_commit_cnt = cnt_q;

endmodule

// File: tb/tb_wbu_commit.sv
// Bench for wbu_commit: directed steps plus a randomized phase, checked against
// a queue-based record model (expected records in delivery order, at most two buffered).
module tb_wbu_commit;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_wb_ready = 1'b0;
  logic [63:0] i_pc = '0, i_imm = '0, i_rs1 = '0, i_exu_res = '0, i_csr = '0;
  logic [4:0]  i_rd = '0;
  logic        i_rd_wen = 1'b0;
  logic [2:0]  i_kind = '0;

  logic        o_ready, o_wb_valid, o_rf_wen, o_csr_wen, o_redirect, o_illegal, o_halt;
  logic [4:0]  o_rf_waddr;
  logic [63:0] o_rf_wdata, o_csr_wdata, o_commit_pc, o_next_pc, o_arch_pc, o_commit_cnt;

  wbu_commit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_imm(i_imm), .i_rs1(i_rs1), .i_exu_res(i_exu_res), .i_csr(i_csr),
    .i_rd(i_rd), .i_rd_wen(i_rd_wen), .i_kind(i_kind),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
    .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_csr_wen(o_csr_wen), .o_csr_wdata(o_csr_wdata), .o_commit_pc(o_commit_pc),
    .o_next_pc(o_next_pc), .o_redirect(o_redirect), .o_illegal(o_illegal),
    .o_halt(o_halt), .o_arch_pc(o_arch_pc), .o_commit_cnt(o_commit_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rf_wen;
    logic        writer;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        csr_wen;
    logic [63:0] csr_wdata;
    logic [63:0] pc;
    logic [63:0] npc;
    logic        redirect;
    logic        illegal;
  } exp_t;

  exp_t        q[$];
  logic        m_ready = 1'b0;
  logic        m_halt = 1'b0;
  logic [63:0] m_arch = RST_PC;
  logic [63:0] m_cnt = '0;
  logic        last_acc = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected record straight from the instruction-kind rules.
  function automatic exp_t mk(input logic [2:0] k, input logic [63:0] pc, imm, rs1, res, csr,
                              input logic [4:0] rd, input logic wen);
    exp_t e;
    e = '{rf_wen:0, writer:0, waddr:rd, wdata:0, csr_wen:0, csr_wdata:0,
          pc:pc, npc:pc + 64'd4, redirect:0, illegal:0};
    case (k)
      3'd0: begin e.writer = 1; e.wdata = res; end
      3'd1: if (res[0]) begin e.npc = pc + imm; e.redirect = 1; end
      3'd2: begin e.writer = 1; e.wdata = res; e.npc = pc + imm; e.redirect = 1; end
      3'd3: begin e.writer = 1; e.wdata = res; e.npc = (rs1 + imm) & ~64'd1; e.redirect = 1; end
      3'd4: begin e.writer = 1; e.wdata = csr; e.csr_wen = 1; e.csr_wdata = res; end
      3'd5: ;
      default: e.illegal = 1;
    endcase
    e.rf_wen = e.writer && wen && (rd != 5'd0);
    return e;
  endfunction

  // One clock: compare outputs with the model, then advance the model across the edge.
  task automatic cyc();
    exp_t e, enew;
    logic acc, drn, ebrk;
    chk("ready", o_ready, m_ready);
    chk("wb_valid", o_wb_valid, q.size() != 0);
    chk("halt", o_halt, m_halt);
    chk("arch_pc", o_arch_pc, m_arch);
    chk("commit_cnt", o_commit_cnt, m_cnt);
    if (q.size() != 0) begin
      e = q[0];
      chk("rf_wen", o_rf_wen, e.rf_wen);
      if (e.writer) begin
        chk("rf_waddr", o_rf_waddr, e.waddr);
        chk("rf_wdata", o_rf_wdata, e.wdata);
      end
      chk("csr_wen", o_csr_wen, e.csr_wen);
      if (e.csr_wen) chk("csr_wdata", o_csr_wdata, e.csr_wdata);
      chk("commit_pc", o_commit_pc, e.pc);
      chk("next_pc", o_next_pc, e.npc);
      chk("redirect", o_redirect, e.redirect);
      chk("illegal", o_illegal, e.illegal);
    end
    acc  = i_valid && m_ready;
    drn  = (q.size() != 0) && i_wb_ready;
    ebrk = (i_kind == 3'd5);
    enew = mk(i_kind, i_pc, i_imm, i_rs1, i_exu_res, i_csr, i_rd, i_rd_wen);
    @(posedge i_clk);
    if (drn) begin
      e = q.pop_front();
      m_cnt = m_cnt + 64'd1;
    end
    if (acc) begin
      q.push_back(enew);
      m_arch = enew.npc;
      if (ebrk) m_halt = 1'b1;
    end
    m_ready  = (q.size() < 2) && !m_halt;
    last_acc = acc;
    @(negedge i_clk);
  endtask

  task automatic set_in(input logic [2:0] k, input logic [63:0] pc, imm, rs1, res, csr,
                        input logic [4:0] rd, input logic wen);
    i_kind = k; i_pc = pc; i_imm = imm; i_rs1 = rs1; i_exu_res = res; i_csr = csr;
    i_rd = rd; i_rd_wen = wen;
  endtask

  task automatic send(input logic [2:0] k, input logic [63:0] pc, imm, rs1, res, csr,
                      input logic [4:0] rd, input logic wen);
    set_in(k, pc, imm, rs1, res, csr, rd, wen);
    i_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (last_acc) break;
    end
    chk("send_accepted", last_acc, 1'b1);
    i_valid = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_wb_valid", o_wb_valid, 1'b0);
    chk("rst_rf_wen", o_rf_wen, 1'b0);
    chk("rst_rf_waddr", o_rf_waddr, 5'd0);
    chk("rst_rf_wdata", o_rf_wdata, 64'd0);
    chk("rst_csr_wen", o_csr_wen, 1'b0);
    chk("rst_csr_wdata", o_csr_wdata, 64'd0);
    chk("rst_commit_pc", o_commit_pc, 64'd0);
    chk("rst_next_pc", o_next_pc, 64'd0);
    chk("rst_redirect", o_redirect, 1'b0);
    chk("rst_illegal", o_illegal, 1'b0);
    chk("rst_halt", o_halt, 1'b0);
    chk("rst_arch_pc", o_arch_pc, RST_PC);
    chk("rst_cnt", o_commit_cnt, 64'd0);
  endtask

  // Asynchronous reset mid-cycle, then release on the next falling edge.
  task automatic reset_mid();
    #2 i_rst_n = 1'b0;
    #1 chk_reset_state();
    q.delete();
    m_ready = 1'b0; m_halt = 1'b0; m_arch = RST_PC; m_cnt = '0;
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0]  kinds [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    logic [63:0] base;
    logic [63:0] npc_a;

    repeat (2) @(negedge i_clk);
    chk_reset_state();
    i_rst_n = 1'b1;

    // ALU after reset
    i_wb_ready = 1'b1;
    send(3'd0, 64'h8000_0000, 64'd0, 64'd0, 64'h1234, 64'd0, 5'd5, 1'b1);
    chk("alu_wb_valid", o_wb_valid, 1'b1);
    chk("alu_rf_wen", o_rf_wen, 1'b1);
    chk("alu_waddr", o_rf_waddr, 5'd5);
    chk("alu_wdata", o_rf_wdata, 64'h1234);
    chk("alu_next_pc", o_next_pc, 64'h8000_0004);
    chk("alu_arch_pc", o_arch_pc, 64'h8000_0004);
    cyc();
    chk("alu_cnt", o_commit_cnt, 64'd1);

    // Branch taken / not taken
    send(3'd1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd1, 64'd0, 5'd7, 1'b1);
    chk("br_t_next_pc", o_next_pc, 64'h8000_0008);
    chk("br_t_redirect", o_redirect, 1'b1);
    chk("br_t_rf_wen", o_rf_wen, 1'b0);
    send(3'd1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 64'd0, 5'd7, 1'b1);
    chk("br_n_next_pc", o_next_pc, 64'h8000_0014);
    chk("br_n_redirect", o_redirect, 1'b0);
    chk("br_n_rf_wen", o_rf_wen, 1'b0);

    // JALR target and x0 suppression
    send(3'd3, 64'h8000_0020, 64'd2, 64'h8000_0101, 64'h8000_0024, 64'd0, 5'd1, 1'b1);
    chk("jalr_next_pc", o_next_pc, 64'h8000_0102);
    chk("jalr_wdata", o_rf_wdata, 64'h8000_0024);
    send(3'd0, 64'h8000_0102, 64'd0, 64'd0, 64'h77, 64'd0, 5'd0, 1'b1);
    chk("alu_x0_rf_wen", o_rf_wen, 1'b0);
    repeat (2) cyc();

    // Back-pressure: two records fill the buffer, the third waits
    base = m_cnt;
    i_wb_ready = 1'b0;
    send(3'd0, 64'h8000_0200, 64'd0, 64'd0, 64'hA1, 64'd0, 5'd10, 1'b1);
    npc_a = 64'h8000_0204;
    send(3'd0, 64'h8000_0204, 64'd0, 64'd0, 64'hA2, 64'd0, 5'd11, 1'b1);
    chk("bp_ready_low", o_ready, 1'b0);
    set_in(3'd0, 64'h8000_0208, 64'd0, 64'd0, 64'hA3, 64'd0, 5'd12, 1'b1);
    i_valid = 1'b1;
    repeat (3) cyc();
    chk("bp_hold_next_pc", o_next_pc, npc_a);
    chk("bp_hold_wdata", o_rf_wdata, 64'hA1);
    i_wb_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (last_acc) break;
    end
    chk("bp_third_accepted", last_acc, 1'b1);
    i_valid = 1'b0;
    repeat (4) cyc();
    chk("bp_cnt", o_commit_cnt, base + 64'd3);

    // Randomized phase (no EBREAK so the pipe keeps flowing)
    for (int n = 0; n < 400; n++) begin
      i_wb_ready = ($urandom_range(0, 3) != 0);
      i_valid    = $urandom_range(0, 1);
      set_in(kinds[$urandom_range(0, 6)], {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      cyc();
    end
    i_valid = 1'b0;
    i_wb_ready = 1'b1;
    repeat (3) cyc();

    // Reset while the buffer is full
    i_wb_ready = 1'b0;
    send(3'd0, 64'h8000_0300, 64'd0, 64'd0, 64'hB1, 64'd0, 5'd2, 1'b1);
    send(3'd2, 64'h8000_0304, 64'h40, 64'd0, 64'h8000_0308, 64'd0, 5'd1, 1'b1);
    chk("full_ready_low", o_ready, 1'b0);
    reset_mid();
    i_wb_ready = 1'b1;
    repeat (3) cyc();

    // CSR, reserved kind, then EBREAK
    send(3'd4, 64'h8000_0400, 64'd0, 64'd0, 64'h55, 64'hAA, 5'd3, 1'b1);
    chk("csr_wdata", o_rf_wdata, 64'hAA);
    chk("csr_wen", o_csr_wen, 1'b1);
    chk("csr_csr_wdata", o_csr_wdata, 64'h55);
    send(3'd7, 64'h8000_0404, 64'd0, 64'd0, 64'h9, 64'd0, 5'd4, 1'b1);
    chk("rsv_illegal", o_illegal, 1'b1);
    chk("rsv_rf_wen", o_rf_wen, 1'b0);
    chk("rsv_csr_wen", o_csr_wen, 1'b0);
    i_wb_ready = 1'b0;
    send(3'd5, 64'h8000_0408, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    chk("ebreak_halt", o_halt, 1'b1);
    chk("ebreak_ready", o_ready, 1'b0);
    set_in(3'd0, 64'h8000_0500, 64'd0, 64'd0, 64'hEE, 64'd0, 5'd9, 1'b1);
    i_valid = 1'b1;
    repeat (3) cyc();
    base = m_cnt;
    i_wb_ready = 1'b1;
    repeat (4) cyc();
    chk("ebreak_drained_cnt", o_commit_cnt, base + 64'd2);
    chk("halt_ready_stays_low", o_ready, 1'b0);
    i_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
